// File: rtl/float_to_int_cvt_if.sv
// Handshake and data bundle between the FPU sequencer and float_to_int_cvt.
// The master side drives requests; the slave side is the converter.
interface float_to_int_cvt_if #(
    parameter int OUT_W = 32
);
    logic             en;
    logic             start;
    logic [31:0]      input_a;
    logic             signed_mode;
    logic [1:0]       round_mode;
    logic             busy;
    logic             complete;
    logic [OUT_W-1:0] output_z;
    logic             flag_invalid;
    logic             flag_overflow;
    logic             flag_inexact;

    modport master (
        output en, start, input_a, signed_mode, round_mode,
        input  busy, complete, output_z,
        input  flag_invalid, flag_overflow, flag_inexact
    );

    modport slave (
        input  en, start, input_a, signed_mode, round_mode,
        output busy, complete, output_z,
        output flag_invalid, flag_overflow, flag_inexact
    );
endinterface

// File: rtl/float_to_int_cvt.sv
// Iterative binary32 to OUT_W-bit signed/unsigned integer converter.
// Define FTOI_FAST_SHIFT_EN to shift up to 8 bits per SHIFT cycle.
module float_to_int_cvt #(
    parameter int OUT_W = 32
) (
    input  logic clk,
    input  logic rst,
    float_to_int_cvt_if.slave bus
);
    localparam int MW = OUT_W + 1;
    localparam logic signed [9:0] EMAX = 10'(OUT_W - 1);

    typedef enum logic [2:0] {
        IDLE, UNPACK, SPECIAL, SHIFT, ROUND, PACK
    } state_t;

    state_t            state;
    logic [31:0]       a_q;
    logic              sgn_q;
    logic [1:0]        rm_q;
    logic              s;
    logic signed [9:0] e;
    logic [MW-1:0]     mag;
    logic              guard;
    logic              sticky;
    logic              nan_q;
    logic              ovf_q;

    logic [OUT_W-1:0]  z_q;
    logic              complete_q;
    logic              inv_q;
    logic              ovfl_q;
    logic              inx_q;

    logic [7:0]        exp_f;
    logic [22:0]       frac_f;
    assign exp_f  = a_q[30:23];
    assign frac_f = a_q[22:0];

    assign bus.busy          = (state != IDLE);
    assign bus.complete      = complete_q;
    assign bus.output_z      = z_q;
    assign bus.flag_invalid  = inv_q;
    assign bus.flag_overflow = ovfl_q;
    assign bus.flag_inexact  = inx_q;

    // Rounding increment decision for the captured mode
    logic round_up;
    always_comb begin
        round_up = 1'b0;
        unique case (rm_q)
            2'b00: round_up = guard & (sticky | mag[0]);
            2'b01: round_up = 1'b0;
            2'b10: round_up = ~s & (guard | sticky);
            2'b11: round_up = s & (guard | sticky);
            default: round_up = 1'b0;
        endcase
    end

`ifdef FTOI_FAST_SHIFT_EN
    logic [9:0]    dist;
    logic [3:0]    k;
    logic [MW-1:0] sh_mag;
    logic [MW-1:0] sh_tmp;
    logic [MW-1:0] low_mask;
    logic          sh_guard;
    logic          sh_low;

    // Multi-bit shift step: k bits out, last one is guard, rest fold into sticky
    always_comb begin
        dist     = 10'(EMAX - e);
        k        = (dist > 10'd8) ? 4'd8 : dist[3:0];
        sh_mag   = mag >> k;
        sh_tmp   = mag >> (k - 4'd1);
        sh_guard = sh_tmp[0];
        low_mask = (MW'(1) << (k - 4'd1)) - MW'(1);
        sh_low   = |(mag & low_mask);
    end
`endif

    logic [OUT_W-1:0] smax;
    logic [OUT_W-1:0] smin;
    logic [MW-1:0]    neg_mag;
    logic [OUT_W-1:0] pz;
    logic             p_inv;
    logic             p_ovf;
    logic             p_inx;

    assign smax    = {1'b0, {(OUT_W-1){1'b1}}};
    assign smin    = {1'b1, {(OUT_W-1){1'b0}}};
    assign neg_mag = -mag;

    // Final range check and saturation; flags are mutually exclusive
    always_comb begin
        pz    = '0;
        p_inv = 1'b0;
        p_ovf = 1'b0;
        p_inx = 1'b0;
        if (nan_q) begin
            p_inv = 1'b1;
            pz    = sgn_q ? smax : '1;
        end else if (ovf_q) begin
            p_ovf = 1'b1;
            pz    = sgn_q ? (s ? smin : smax) : (s ? '0 : '1);
        end else if (!sgn_q && s && (mag != '0)) begin
            p_ovf = 1'b1;
            pz    = '0;
        end else if (!sgn_q && !s && mag[OUT_W]) begin
            p_ovf = 1'b1;
            pz    = '1;
        end else if (sgn_q && !s && (mag[OUT_W] | mag[OUT_W-1])) begin
            p_ovf = 1'b1;
            pz    = smax;
        end else if (sgn_q && s &&
                     (mag[OUT_W] | (mag[OUT_W-1] & |mag[OUT_W-2:0]))) begin
            p_ovf = 1'b1;
            pz    = smin;
        end else begin
            pz    = s ? neg_mag[OUT_W-1:0] : mag[OUT_W-1:0];
            p_inx = guard | sticky;
        end
    end

    // Conversion sequencer with registered results
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            a_q        <= '0;
            sgn_q      <= 1'b0;
            rm_q       <= 2'b00;
            s          <= 1'b0;
            e          <= '0;
            mag        <= '0;
            guard      <= 1'b0;
            sticky     <= 1'b0;
            nan_q      <= 1'b0;
            ovf_q      <= 1'b0;
            z_q        <= '0;
            complete_q <= 1'b0;
            inv_q      <= 1'b0;
            ovfl_q     <= 1'b0;
            inx_q      <= 1'b0;
        end else if (!bus.en) begin
            state      <= IDLE;
            z_q        <= '0;
            complete_q <= 1'b0;
            inv_q      <= 1'b0;
            ovfl_q     <= 1'b0;
            inx_q      <= 1'b0;
        end else begin
            complete_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_q   <= bus.input_a;
                        sgn_q <= bus.signed_mode;
                        rm_q  <= bus.round_mode;
                        state <= UNPACK;
                    end
                end
                UNPACK: begin
                    s      <= a_q[31];
                    e      <= $signed({2'b00, exp_f}) - 10'sd127;
                    mag    <= MW'({1'b1, frac_f}) << (OUT_W - 24);
                    guard  <= 1'b0;
                    sticky <= 1'b0;
                    nan_q  <= 1'b0;
                    ovf_q  <= 1'b0;
                    state  <= SPECIAL;
                end
                SPECIAL: begin
                    if (exp_f == 8'hFF && frac_f != '0) begin
                        nan_q <= 1'b1;
                        state <= PACK;
                    end else if (exp_f == 8'hFF || e > EMAX) begin
                        ovf_q <= 1'b1;
                        state <= PACK;
                    end else if (exp_f == 8'h00) begin
                        mag    <= '0;
                        guard  <= 1'b0;
                        sticky <= |frac_f;
                        state  <= ROUND;
                    end else if (e < -10'sd1) begin
                        mag    <= '0;
                        guard  <= 1'b0;
                        sticky <= 1'b1;
                        state  <= ROUND;
                    end else begin
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (e < EMAX) begin
`ifdef FTOI_FAST_SHIFT_EN
                        mag    <= sh_mag;
                        e      <= e + $signed({6'b0, k});
                        guard  <= sh_guard;
                        sticky <= sticky | guard | sh_low;
`else
                        mag    <= mag >> 1;
                        e      <= e + 10'sd1;
                        guard  <= mag[0];
                        sticky <= sticky | guard;
`endif
                    end else begin
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    mag   <= mag + MW'(round_up);
                    state <= PACK;
                end
                PACK: begin
                    z_q        <= pz;
                    inv_q      <= p_inv;
                    ovfl_q     <= p_ovf;
                    inx_q      <= p_inx;
                    complete_q <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
